// File: rtl/syscall_unit.sv
// syscall_unit: services syscall instructions flagged by decode.
//   Service 1  (print integer): sends $a0 to the display sink.
//   Service 11 (print char)   : sends the low byte of $a0, zero-extended.
//   Service 10 (exit)         : halts for good. Only reset leaves this state.
//   Any other service number  : pulses bad_syscall, then completes.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   syscall_valid, syscall_v0  syscall request and its service number
//   syscall_a0                 $a0 from the register file
//   print_a0                   strobe that makes the register file latch $a0
//   stall, halt                pipeline hold while in service; sticky halt
//   disp_data/valid/ready      display payload handshake
//   bad_syscall, done          one-cycle status pulses
//   syscall_count              completed non-exit syscalls, saturating
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for syscall_valid; latches the service number
// DISPATCH | decode the latched service number
// CAPTURE  | print_a0 high; the register file latches $a0
// WAIT     | $a0 is settled; load disp_data
// SEND     | disp_valid high until the sink accepts
// DONE     | pulse done and bump the count
// HALTED   | program exited; only reset leaves this state
module syscall_unit #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               syscall_valid,
    input  logic [31:0]        syscall_v0,
    input  logic [31:0]        syscall_a0,
    output logic               print_a0,
    output logic               stall,
    output logic               halt,
    output logic [31:0]        disp_data,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic               bad_syscall,
    output logic               done,
    output logic [COUNT_W-1:0] syscall_count
);

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_CAPTURE,
        S_WAIT,
        S_SEND,
        S_DONE,
        S_HALTED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] svc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            svc           <= '0;
            print_a0      <= 1'b0;
            disp_data     <= '0;
            syscall_count <= '0;
        end else begin
            state_q <= state_d;
            // svc is captured only here, so later changes on $v0 are ignored.
            if (state_q == S_IDLE && syscall_valid) begin
                svc <= syscall_v0;
            end
            // Registered from next state so the strobe is a clean flop output.
            print_a0 <= (state_d == S_CAPTURE);
            if (state_q == S_WAIT) begin
                disp_data <= (svc == SVC_PRINT_CHAR) ? {24'b0, syscall_a0[7:0]}
                                                     : syscall_a0;
            end
            if (state_q == S_DONE && !(&syscall_count)) begin
                syscall_count <= syscall_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        halt        = 1'b0;
        disp_valid  = 1'b0;
        bad_syscall = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (syscall_valid) begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                stall = 1'b1;
                if (svc == SVC_EXIT) begin
                    state_d = S_HALTED;
                end else if (svc == SVC_PRINT_INT || svc == SVC_PRINT_CHAR) begin
                    state_d = S_CAPTURE;
                end else begin
                    bad_syscall = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_CAPTURE: begin
                stall   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall   = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                stall      = 1'b1;
                disp_valid = 1'b1;
                if (disp_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_HALTED: begin
                stall = 1'b1;
                halt  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        syscall_valid = 1'b0;
    logic [31:0] syscall_v0 = '0;
    logic [31:0] syscall_a0 = '0;
    logic        print_a0;
    logic        stall;
    logic        halt;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        disp_ready = 1'b1;
    logic        bad_syscall;
    logic        done;
    logic [15:0] syscall_count;

    // Second instance with a 2-bit counter for the saturation case.
    logic        s_valid = 1'b0;
    logic [31:0] s_v0 = '0;
    logic [31:0] s_a0 = '0;
    logic        s_ready = 1'b1;
    logic        s_print_a0, s_stall, s_halt, s_disp_valid, s_bad, s_done;
    logic [31:0] s_disp_data;
    logic [1:0]  s_count;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] exp_data[$];
    logic [15:0] exp_count[$];

    always #5 clk = ~clk;

    syscall_unit dut (
        .clk(clk), .reset(reset),
        .syscall_valid(syscall_valid), .syscall_v0(syscall_v0), .syscall_a0(syscall_a0),
        .print_a0(print_a0), .stall(stall), .halt(halt),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .bad_syscall(bad_syscall), .done(done), .syscall_count(syscall_count)
    );

    syscall_unit #(.COUNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .syscall_valid(s_valid), .syscall_v0(s_v0), .syscall_a0(s_a0),
        .print_a0(s_print_a0), .stall(s_stall), .halt(s_halt),
        .disp_data(s_disp_data), .disp_valid(s_disp_valid), .disp_ready(s_ready),
        .bad_syscall(s_bad), .done(s_done), .syscall_count(s_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    // Drives a request into edge T and returns at the sample point of cycle T+1.
    // $v0 is then scrambled to show the latched service number is what counts.
    task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
        @(negedge clk);
        syscall_valid = 1'b1;
        syscall_v0    = v0;
        syscall_a0    = a0;
        @(negedge clk);
        syscall_valid = 1'b0;
        syscall_v0    = 32'hDEAD_BEEF;
    endtask

    task automatic issue_s(input logic [31:0] v0, input logic [31:0] a0);
        @(negedge clk);
        s_valid = 1'b1;
        s_v0    = v0;
        s_a0    = a0;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl"}, {58'b0, print_a0, stall, halt, disp_valid, bad_syscall, done}, 64'd0);
        check({name, " data"}, {32'b0, disp_data}, 64'd0);
        check({name, " count"}, {48'b0, syscall_count}, 64'd0);
    endtask

    // Monitor: consumes expected display payloads on each transfer and expected
    // counts the cycle after each done pulse.
    initial begin
        logic count_pend;
        count_pend = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (count_pend) begin
                count_pend = 1'b0;
                if (exp_count.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: count %0d with no expectation", syscall_count);
                end else begin
                    check("sb_count", {48'b0, syscall_count}, {48'b0, exp_count.pop_front()});
                end
            end
            if (disp_valid && disp_ready) begin
                if (exp_data.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_transfer: data %h with no expectation", disp_data);
                end else begin
                    check("sb_disp_data", {32'b0, disp_data}, {32'b0, exp_data.pop_front()});
                end
            end
            if (done && bad_syscall) begin
                n_chk++; n_err++;
                $display("FAIL done_and_bad: both high, required one at most");
            end
            if (done && !reset) count_pend = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        logic [1:0] sat_exp [5];
        bit         bad_seen;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        repeat (3) next();
        check_reset_outputs("reset");
        reset = 1'b0;
        next();

        // Print integer, sink always ready
        disp_ready = 1'b1;
        exp_data.push_back(32'hFFFF_FFFE);
        exp_count.push_back(16'd1);
        issue(32'd1, 32'hFFFF_FFFE);                      // T+1
        check("int T+1 stall/print", {62'b0, stall, print_a0}, 64'b10);
        next();                                           // T+2
        check("int T+2 print_a0", {63'b0, print_a0}, 64'd1);
        next();                                           // T+3
        check("int T+3 print/valid", {62'b0, print_a0, disp_valid}, 64'b00);
        next();                                           // T+4
        check("int T+4 valid", {63'b0, disp_valid}, 64'd1);
        check("int T+4 data", {32'b0, disp_data}, 64'hFFFF_FFFE);
        next();                                           // T+5
        check("int T+5 done/valid", {62'b0, done, disp_valid}, 64'b10);
        next();                                           // T+6
        check("int T+6 idle", {62'b0, stall, done}, 64'b00);
        check("int count", {48'b0, syscall_count}, 64'd1);

        // Print char with 3 cycles of backpressure
        disp_ready = 1'b0;
        exp_data.push_back(32'h0000_0041);
        exp_count.push_back(16'd2);
        issue(32'd11, 32'h1234_5641);
        repeat (3) next();                                // T+4
        for (int i = 0; i < 3; i++) begin
            check("chr held", {29'b0, disp_valid, stall, done, disp_data}, {29'b0, 3'b110, 32'h41});
            next();
        end
        disp_ready = 1'b1;                                // T+7: 4th valid cycle
        check("chr accept", {29'b0, disp_valid, stall, done, disp_data}, {29'b0, 3'b110, 32'h41});
        next();
        check("chr done", {62'b0, done, disp_valid}, 64'b10);
        next();
        check("chr count", {48'b0, syscall_count}, 64'd2);

        // Unsupported service
        exp_count.push_back(16'd3);
        issue(32'd5, 32'h0);                              // T+1
        check("bad T+1", {60'b0, bad_syscall, done, print_a0, disp_valid}, 64'b1000);
        next();                                           // T+2
        check("bad T+2", {60'b0, bad_syscall, done, print_a0, disp_valid}, 64'b0100);
        next();
        check("bad count", {48'b0, syscall_count}, 64'd3);

        // Reset while in SEND, then a clean syscall
        disp_ready = 1'b0;
        issue(32'd1, 32'h0000_00A5);
        repeat (3) next();                                // T+4
        check("rst pre valid", {63'b0, disp_valid}, 64'd1);
        reset = 1'b1;
        next();
        check_reset_outputs("rst in send");
        reset = 1'b0;
        disp_ready = 1'b1;
        exp_data.push_back(32'h0000_0007);
        exp_count.push_back(16'd1);
        issue(32'd1, 32'h0000_0007);
        repeat (5) next();                                // T+6
        check("post rst count", {48'b0, syscall_count}, 64'd1);

        // Exit, then a syscall that must be ignored
        issue(32'd10, 32'h0);                             // T+1
        check("exit T+1", {62'b0, halt, stall}, 64'b01);
        next();                                           // T+2
        check("exit T+2", {62'b0, halt, stall}, 64'b11);
        bad_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            syscall_valid = (i == 2);
            syscall_v0    = 32'd1;
            next();
            if (!halt || !stall || print_a0 || disp_valid || done || bad_syscall) bad_seen = 1'b1;
        end
        syscall_valid = 1'b0;
        check("halted stays", {63'b0, bad_seen}, 64'd0);
        check("halted count", {48'b0, syscall_count}, 64'd1);
        reset = 1'b1;
        next();
        check_reset_outputs("rst in halted");
        reset = 1'b0;

        // Saturating 2-bit counter
        for (int k = 0; k < 5; k++) begin
            issue_s(32'd1, 32'(k));
            repeat (5) next();                            // T+6
            check($sformatf("sat count %0d", k), {62'b0, s_count}, {62'b0, sat_exp[k]});
        end

        repeat (3) next();
        check("sb data drained", 64'(exp_data.size()), 64'd0);
        check("sb count drained", 64'(exp_count.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
